i2s_frame_ctrl: RTL and testbench

I2S master-mode frame controller for the codec audio path. Divides the system clock to produce BCLK and LRCLK, and deserializes ADCDAT into signed 16-bit left/right samples. It serializes signed 16-bit DAC samples onto DACDAT and hands both sample streams to the effects datapath with one-cycle strobes. It sits between the codec pins and the distortion chain, and is the only block that drives codec timing.

---
 rtl/i2s_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_ctrl.sv
// rtl/i2s_frame_ctrl.sv - I2S master frame controller: BCLK/LRCLK generation, ADC capture, DAC serialisation.
// Optional macro I2S_LOOPBACK_EN: DAC holding registers reload from the last captured ADC samples.
module i2s_frame_ctrl #(
  parameter int BCLK_HALF = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_adcdat,
  input  logic [15:0] i_dac_left,
  input  logic [15:0] i_dac_right,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_dacdat,
  output logic [15:0] o_adc_left,
  output logic [15:0] o_adc_right,
  output logic        o_adc_valid,
  output logic        o_dac_load
);

  localparam int DW = $clog2(BCLK_HALF);
  localparam logic [DW-1:0] TC = DW'(BCLK_HALF - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [DW-1:0] r_div_cnt;
  logic [5:0]  r_bit_cnt;
  logic        r_bclk;
  logic        r_dacdat;
  logic [15:0] r_adc_shift;
  logic [15:0] r_left_word;
  logic [15:0] r_adc_left;
  logic [15:0] r_adc_right;
  logic        r_adc_valid;
  logic [15:0] r_hold_left;
  logic [15:0] r_hold_right;
  logic        r_dac_load;

  logic        w_active;
  logic        w_start;
  logic        w_tc;
  logic        w_rise;
  logic        w_fall;
  logic        w_wrap;
  logic        w_load;
  logic [5:0]  w_next_bit;
  logic [4:0]  w_next_slot;
  logic [3:0]  w_dac_idx;
  logic [15:0] w_dac_word;
  logic        w_dac_bit;
  logic        w_adc_slot;
  logic [15:0] w_adc_word;
  logic [15:0] w_load_left;
  logic [15:0] w_load_right;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // ENABLE is only honoured at the frame boundary once a frame is running
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_enable) w_next_state = S_RUN;
      S_RUN: begin
        if (w_wrap)         w_next_state = i_enable ? S_RUN : S_IDLE;
        else if (!i_enable) w_next_state = S_DRAIN;
      end
      S_DRAIN: if (w_wrap) w_next_state = i_enable ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_active = 1'b0;
    w_start  = 1'b0;
    case (r_state)
      S_IDLE:         w_start  = i_enable;
      S_RUN, S_DRAIN: w_active = 1'b1;
      default: begin
        w_active = 1'b0;
        w_start  = 1'b0;
      end
    endcase
  end

  assign w_tc   = (r_div_cnt == TC);
  assign w_rise = w_active & w_tc & ~r_bclk;
  assign w_fall = w_active & w_tc & r_bclk;
  assign w_wrap = w_fall & (r_bit_cnt == 6'd63);
  assign w_load = w_start | (w_wrap & i_enable);

  // slot s (1..16) carries bit 16-s, i.e. index -s modulo 16
  assign w_next_bit  = r_bit_cnt + 6'd1;
  assign w_next_slot = w_next_bit[4:0];
  assign w_dac_idx   = 4'd0 - w_next_slot[3:0];
  assign w_dac_word  = w_next_bit[5] ? r_hold_right : r_hold_left;
  assign w_dac_bit   = (w_next_slot != 5'd0) && (w_next_slot <= 5'd16) && w_dac_word[w_dac_idx];

  assign w_adc_slot = (r_bit_cnt[4:0] != 5'd0) && (r_bit_cnt[4:0] <= 5'd16);
  assign w_adc_word = {r_adc_shift[14:0], i_adcdat};

`ifdef I2S_LOOPBACK_EN
  assign w_load_left  = r_adc_left;
  assign w_load_right = r_adc_right;
`else
  assign w_load_left  = i_dac_left;
  assign w_load_right = i_dac_right;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_bit_cnt <= 6'd0;
      r_bclk    <= 1'b0;
      r_dacdat  <= 1'b0;
    end else if (!w_active) begin
      r_div_cnt <= '0;
      r_bit_cnt <= 6'd0;
      r_bclk    <= 1'b0;
      r_dacdat  <= 1'b0;
    end else begin
      if (w_tc) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_next_bit;
        r_dacdat  <= w_dac_bit;
      end
    end
  end

  // left word parks in r_left_word so both outputs change in the same cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_adc_shift <= 16'd0;
      r_left_word <= 16'd0;
      r_adc_left  <= 16'd0;
      r_adc_right <= 16'd0;
      r_adc_valid <= 1'b0;
    end else begin
      r_adc_valid <= 1'b0;
      if (w_rise && w_adc_slot) begin
        r_adc_shift <= w_adc_word;
        if (r_bit_cnt == 6'd16) r_left_word <= w_adc_word;
        if (r_bit_cnt == 6'd48) begin
          r_adc_left  <= r_left_word;
          r_adc_right <= w_adc_word;
          r_adc_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_left  <= 16'd0;
      r_hold_right <= 16'd0;
      r_dac_load   <= 1'b0;
    end else begin
      r_dac_load <= w_load;
      if (w_load) begin
        r_hold_left  <= w_load_left;
        r_hold_right <= w_load_right;
      end
    end
  end

  assign o_bclk      = r_bclk;
  assign o_lrclk     = r_bit_cnt[5];
  assign o_dacdat    = r_dacdat;
  assign o_adc_left  = r_adc_left;
  assign o_adc_right = r_adc_right;
  assign o_adc_valid = r_adc_valid;
  assign o_dac_load  = r_dac_load;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// tb/tb_i2s_frame_ctrl.sv - scoreboard bench with a slot-counting codec model for i2s_frame_ctrl.
`timescale 1ns/1ps
module tb_i2s_frame_ctrl;
  localparam int H = 4;
  localparam int FRAME = 128 * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adcdat = 1'b0;
  logic [15:0] dac_left = 16'hA5A5;
  logic [15:0] dac_right = 16'h0F0F;
  logic        o_bclk, o_lrclk, o_dacdat, o_adc_valid, o_dac_load;
  logic [15:0] o_adc_left, o_adc_right;

  i2s_frame_ctrl #(.BCLK_HALF(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_adcdat(adcdat),
    .i_dac_left(dac_left), .i_dac_right(dac_right),
    .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_dacdat(o_dacdat),
    .o_adc_left(o_adc_left), .o_adc_right(o_adc_right),
    .o_adc_valid(o_adc_valid), .o_dac_load(o_dac_load)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_adc[$];
  logic [31:0] exp_dac[$];
  logic [31:0] codec_dir[$];
  logic [31:0] codec_word = 32'd0;
  logic [31:0] last_adc = 32'd0;
  logic [31:0] dac_acc = 32'd0;
  logic [31:0] e;
  int cyc = 0, pos = 0, last_rise = -1, last_lr_rise = -1, exp_first_rise = -1;
  int low_streak = 0, adc_since = 0, adc_cnt = 0, load_cnt = 0, rise_cnt = 0;
  logic have_load = 1'b0, prev_bclk = 1'b0, prev_lr = 1'b0, rand_dac = 1'b0;
  logic rise, fall, lr_chg;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=missing required=present", nm);
  endtask

  // codec model, monitor and scoreboard
  initial begin
    codec_dir.push_back(32'h8001_7FFE);
    codec_dir.push_back(32'h1234_FEDC);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_adc.delete();
        exp_dac.delete();
        pos = 0; prev_bclk = 1'b0; prev_lr = 1'b0;
        last_rise = -1; last_lr_rise = -1; exp_first_rise = -1;
        low_streak = 0; adc_since = 0; have_load = 1'b0;
        last_adc = 32'd0; dac_acc = 32'd0;
      end else begin
        rise   = o_bclk && !prev_bclk;
        fall   = !o_bclk && prev_bclk;
        lr_chg = (o_lrclk != prev_lr);
        if (o_adc_valid || o_dac_load)
          check("strobe_overlap", {31'd0, o_adc_valid && o_dac_load}, 32'd0);
        if (o_adc_valid) begin
          adc_cnt++;
          adc_since++;
          if (exp_adc.size() == 0) fail_now("adc_unexpected");
          else begin
            e = exp_adc.pop_front();
            check("adc_sample", {o_adc_left, o_adc_right}, e);
            last_adc = e;
          end
        end
        if (o_dac_load) begin
          load_cnt++;
          if (have_load) check("adc_per_frame", adc_since, 32'd1);
          have_load = 1'b1;
          adc_since = 0;
`ifdef I2S_LOOPBACK_EN
          exp_dac.push_back(last_adc);
`else
          exp_dac.push_back({dac_left, dac_right});
`endif
          if (last_rise < 0) exp_first_rise = cyc + H;
        end
        if (rise) begin
          rise_cnt++;
          if (last_rise >= 0) check("bclk_period", cyc - last_rise, 2 * H);
          else if (exp_first_rise >= 0) begin
            check("first_rise", cyc, exp_first_rise);
            exp_first_rise = -1;
          end
          last_rise = cyc;
          if (pos >= 1 && pos <= 16) begin
            dac_acc = {dac_acc[30:0], o_dacdat};
            if (o_lrclk && pos == 16) begin
              if (exp_dac.size() == 0) fail_now("dac_unexpected");
              else check("dac_frame", dac_acc, exp_dac.pop_front());
            end
          end else begin
            check("dac_pad_zero", {31'd0, o_dacdat}, 32'd0);
          end
        end
        if (lr_chg) begin
          check("lr_align", {31'd0, fall}, 32'd1);
          if (o_lrclk) begin
            if (last_lr_rise >= 0) check("lrclk_period", cyc - last_lr_rise, FRAME);
            last_lr_rise = cyc;
          end
        end
        if (fall) begin
          pos = lr_chg ? 0 : pos + 1;
          if (!o_lrclk && pos == 1)
            codec_word = (codec_dir.size() > 0) ? codec_dir.pop_front() : $urandom;
          if (pos >= 1 && pos <= 16) adcdat = o_lrclk ? codec_word[16 - pos] : codec_word[32 - pos];
          else adcdat = 1'($urandom);
          if (o_lrclk && pos == 16) exp_adc.push_back(codec_word);
        end
        if (o_bclk) low_streak = 0;
        else low_streak++;
        if (low_streak > 2 * H) begin
          last_rise = -1;
          last_lr_rise = -1;
        end
        if (rand_dac) begin
          dac_left = 16'($urandom);
          dac_right = 16'($urandom);
        end
        prev_bclk = o_bclk;
        prev_lr = o_lrclk;
      end
    end
  end

  task automatic wait_slot(input logic lr, input int p);
    int n = 0;
    while (!(prev_lr == lr && pos == p) && n < 4 * FRAME) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 4 * FRAME) fail_now("wait_slot_timeout");
  endtask

  task automatic wait_loads(input int k);
    int target = load_cnt + k;
    int n = 0;
    while (load_cnt < target && n < (k + 2) * FRAME) begin
      @(negedge clk); #1;
      n++;
    end
    if (load_cnt < target) fail_now("wait_loads_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (low_streak <= 4 * H && n < 2 * FRAME) begin
      @(negedge clk); #1;
      n++;
    end
    if (low_streak <= 4 * H) fail_now("wait_idle_timeout");
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_bclk"}, {31'd0, o_bclk}, 32'd0);
    check({nm, "_lrclk"}, {31'd0, o_lrclk}, 32'd0);
    check({nm, "_dacdat"}, {31'd0, o_dacdat}, 32'd0);
    check({nm, "_adc"}, {o_adc_left, o_adc_right}, 32'd0);
    check({nm, "_strobes"}, {30'd0, o_adc_valid, o_dac_load}, 32'd0);
  endtask

  initial begin
    int a0, a1, l1, r1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1;
    enable = 1'b1;
    wait_loads(2);
    rand_dac = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_slot(1'b0, int'($urandom_range(2, 25)));
      enable = 1'b0;
      wait_slot(1'b1, int'($urandom_range(1, 25)));
      enable = 1'b1;
    end
    wait_loads(2);

    wait_slot(1'b0, 20);
    a0 = adc_cnt;
    enable = 1'b0;
    wait_idle();
    check("drain_adc_valid", adc_cnt - a0, 32'd1);
    check("drain_adc_queue", exp_adc.size(), 32'd0);
    check("drain_dac_queue", exp_dac.size(), 32'd0);
    a1 = adc_cnt; l1 = load_cnt; r1 = rise_cnt;
    repeat (3 * FRAME) @(negedge clk);
    #1;
    check("idle_adc_strobes", adc_cnt - a1, 32'd0);
    check("idle_dac_strobes", load_cnt - l1, 32'd0);
    check("idle_bclk_rises", rise_cnt - r1, 32'd0);
    check("idle_pins", {29'd0, o_bclk, o_lrclk, o_dacdat}, 32'd0);

    enable = 1'b1;
    wait_loads(2);
    wait_slot(1'b0, 20);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    wait_loads(3);
    wait_slot(1'b0, 10);
    enable = 1'b0;
    wait_idle();
    check("final_adc_queue", exp_adc.size(), 32'd0);
    check("final_dac_queue", exp_dac.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
